serial_adder: RTL and testbench

Bit-serial adder: accepts two WIDTH-bit operands and a carry-in on a start handshake and produces the sum one bit per clock, LSB first. The sum is returned in a registered result word with carry-out and a done pulse. Each bit is computed by one instance of the team's two-half-adder `fulladd` cell, fed from operand shift registers, with the carry held in a flip-flop between cycles. It sits directly upstream of the `fulladd` cell, sequencing its inputs, and is the area-minimal alternative to a ripple adder.

---
 rtl/serial_adder.sv | 142 ++++++++++++++
 tb/tb_serial_adder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one fulladd cell sequenced over WIDTH clocks, LSB first.
// Optional subtract support is enabled by defining SERIAL_ADDER_SUB_EN.

module fulladd (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1;
    logic c1;
    logic c2;

    // Two cascaded half adders.
    assign s1 = a ^ b;
    assign c1 = a & b;
    assign s  = s1 ^ ci;
    assign c2 = s1 & ci;
    assign co = c1 | c2;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // state | meaning
    // IDLE  | waiting for start; operands captured on acceptance
    // RUN   | one sum bit per clock, WIDTH clocks
    // DONE  | sum/cout just updated; one-cycle pulse
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] sum_nxt;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    assign accept  = (state == IDLE) && start;
    assign last    = (state == RUN) && (cnt == CW'(WIDTH - 1));
    assign sum_nxt = {fa_s, acc};

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = b;
    assign c_load     = cin;
`endif

    fulladd u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            RUN:     busy  = 1'b1;
            DONE:    done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // The accumulator holds the low WIDTH-1 result bits; the MSB comes
    // straight from the cell on the final edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            acc   <= sum_nxt[WIDTH-1:1];
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= sum_nxt;
                cout <= fa_c;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: the driver queues expected {cout,sum}
// and done cycle; a monitor checks each done pulse against the queue.

module tb_serial_adder;
    localparam int W = 8;

    typedef struct {
        logic [W:0] res;
        int         cyc;
        string      name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, 32'({cout, sum}), 32'(e.res));
                check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called between a falling and rising edge; leaves start low after acceptance.
    task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic ts, input logic [W:0] exp);
        int k = 0;
        exp_t e;
        while (!ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!ready) timeout({name, "_ready"});
        a = ta;
        b = tb;
        cin = tc;
        sub = ts;
        start = 1'b1;
        e.res = exp;
        e.cyc = cyc + 1 + W;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = ~ta;
        b = 8'hA5;
        cin = ~tc;
        sub = ~ts;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            #2;
            k++;
        end while (!(sb.size() == 0 && ready) && k < 60);
        if (!(sb.size() == 0 && ready)) timeout({name, "_idle"});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", 32'({sum, cout, done, busy, ready}), 32'({8'h00, 1'b0, 1'b0, 1'b0, 1'b1}));
        @(negedge clk);
        rst_n = 1'b1;

        // Start on the first edge after release; sum must hold during RUN.
        do_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 9'h096);
        check("busy_after_accept", 32'({busy, ready}), 32'({1'b1, 1'b0}));
        repeat (3) @(negedge clk);
        check("sum_hold_in_run", 32'({cout, sum}), 32'h0);
        wait_idle("add_5a_3c");

        do_op("add_ff_01_c1", 8'hFF, 8'h01, 1'b1, 1'b0, 9'h101);
        wait_idle("add_ff_01_c1");
        do_op("add_zero", 8'h00, 8'h00, 1'b0, 1'b0, 9'h000);
        wait_idle("add_zero");

        // A start pulse mid-RUN must be ignored.
        do_op("ignore_start", 8'h12, 8'h34, 1'b0, 1'b0, 9'h046);
        repeat (2) @(negedge clk);
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ignore_start");
        repeat (12) @(negedge clk);
        check("no_extra_done", 32'(sb.size()), 32'd0);

        // Reset mid-RUN discards the operation.
        do_op("aborted", 8'h11, 8'h22, 1'b0, 1'b0, 9'h033);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_reset_outputs", 32'({sum, cout, done, busy, ready}), 32'({8'h00, 1'b0, 1'b0, 1'b0, 1'b1}));
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_reset", 8'h07, 8'h08, 1'b0, 1'b0, 9'h00F);
        wait_idle("after_reset");

        // Start held high: each acceptance comes as soon as ready returns.
        a = 8'h01;
        b = 8'h02;
        cin = 1'b0;
        sub = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int k = 0;
            exp_t e;
            while (!ready && k < 40) begin
                @(negedge clk);
                k++;
            end
            if (!ready) timeout("held_ready");
            e.res = 9'h003;
            e.cyc = cyc + 1 + W;
            e.name = "held";
            sb.push_back(e);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle("held");

`ifdef SERIAL_ADDER_SUB_EN
        do_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 9'h10F);
        wait_idle("sub_10_01");
        do_op("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 9'h0FF);
        wait_idle("sub_01_02");
`else
        do_op("sub_ignored", 8'h10, 8'h01, 1'b0, 1'b1, 9'h011);
        wait_idle("sub_ignored");
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: simulation exceeded time limit (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end
endmodule
